// File: rtl/cpuc_acc_alu.sv
// cpuc_package: shared CPUC datapath parameters.
// cpuc_acc_alu: sequential accumulator ALU. The B operand is one of four constant
// words, an immediate, or zero. Single-cycle ops commit at the accept edge.
// MUL is an iterative shift-add that takes DATA_WIDTH cycles.

package cpuc_package;
   localparam int DATA_WIDTH = 8;
endpackage

module cpuc_acc_alu
   import cpuc_package::*;
#(
   parameter int OP_W = 3
)
(
   input  logic                  Clk,
   input  logic                  RstN,
   input  logic [DATA_WIDTH-1:0] const0,
   input  logic [DATA_WIDTH-1:0] const1,
   input  logic [DATA_WIDTH-1:0] const2,
   input  logic [DATA_WIDTH-1:0] const3,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OP_W-1:0]       in_op,
   input  logic [2:0]            in_src_sel,
   input  logic [DATA_WIDTH-1:0] in_imm,
   output logic [DATA_WIDTH-1:0] acc_out,
   output logic                  out_valid,
   output logic                  carry_out,
   output logic                  zero_out
);

   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_LOAD = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SUB  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_AND  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_OR   = OP_W'(5);
   localparam logic [OP_W-1:0] OP_XOR  = OP_W'(6);
   localparam logic [OP_W-1:0] OP_MUL  = OP_W'(7);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     acc_q, acc_d;
   logic             carry_q, carry_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2*W-1:0]   prod_q, prod_d;
   logic [2*W-1:0]   mcand_q, mcand_d;
   logic [W-1:0]     mplier_q, mplier_d;

   logic             accept_s;
   logic [W-1:0]     b_s;
   logic [W:0]       sum_s;
   logic [W:0]       diff_s;
   logic [2*W-1:0]   prod_step_s;

   // B operand mux; selects 5..7 are a legal zero operand.
   always_comb begin
      b_s = {W{1'b0}};
      case (in_src_sel)
         3'd0:    b_s = const0;
         3'd1:    b_s = const1;
         3'd2:    b_s = const2;
         3'd3:    b_s = const3;
         3'd4:    b_s = in_imm;
         default: b_s = {W{1'b0}};
      endcase
   end

   // Shared arithmetic: widened add/sub for carry/borrow, one shift-add step for MUL.
   always_comb begin
      sum_s  = {1'b0, acc_q} + {1'b0, b_s};
      diff_s = {1'b0, acc_q} - {1'b0, b_s};
      if (mplier_q[0]) begin
         prod_step_s = prod_q + mcand_q;
      end else begin
         prod_step_s = prod_q;
      end
   end

   assign accept_s = in_valid && (state_q == ST_IDLE);

   // Next-state logic: command execution in IDLE, iterative multiply in MUL.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      carry_d     = carry_q;
      out_valid_d = 1'b0;
      cnt_d       = cnt_q;
      prod_d      = prod_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               if (in_op == OP_MUL) begin
                  // Operands are frozen here; later input changes cannot disturb the product.
                  state_d  = ST_MUL;
                  prod_d   = {(2*W){1'b0}};
                  mcand_d  = {{W{1'b0}}, acc_q};
                  mplier_d = b_s;
                  cnt_d    = {CNT_W{1'b0}};
               end else begin
                  out_valid_d = 1'b1;
                  case (in_op)
                     OP_NOP: begin
                        acc_d   = acc_q;
                        carry_d = carry_q;
                     end
                     OP_LOAD: begin
                        acc_d   = b_s;
                        carry_d = 1'b0;
                     end
                     OP_ADD: begin
                        acc_d   = sum_s[W-1:0];
                        carry_d = sum_s[W];
                     end
                     OP_SUB: begin
                        acc_d   = diff_s[W-1:0];
                        carry_d = diff_s[W];
                     end
                     OP_AND: begin
                        acc_d   = acc_q & b_s;
                        carry_d = 1'b0;
                     end
                     OP_OR: begin
                        acc_d   = acc_q | b_s;
                        carry_d = 1'b0;
                     end
                     OP_XOR: begin
                        acc_d   = acc_q ^ b_s;
                        carry_d = 1'b0;
                     end
                     default: begin
                        acc_d   = acc_q;
                        carry_d = carry_q;
                     end
                  endcase
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            prod_d   = prod_step_s;
            mcand_d  = {mcand_q[2*W-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[W-1:1]};
            if (cnt_q == CNT_LAST) begin
               acc_d       = prod_step_s[W-1:0];
               carry_d     = |prod_step_s[2*W-1:W];
               out_valid_d = 1'b1;
               cnt_d       = {CNT_W{1'b0}};
               state_d     = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State register; asynchronous reset aborts any multiply in flight.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         state_q     <= ST_IDLE;
         acc_q       <= {W{1'b0}};
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         cnt_q       <= {CNT_W{1'b0}};
         prod_q      <= {(2*W){1'b0}};
         mcand_q     <= {(2*W){1'b0}};
         mplier_q    <= {W{1'b0}};
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         carry_q     <= carry_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
         prod_q      <= prod_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign acc_out   = acc_q;
   assign carry_out = carry_q;
   assign out_valid = out_valid_q;
   assign zero_out  = (acc_q == {W{1'b0}});

endmodule

// File: tb/tb_cpuc_acc_alu.sv
// Directed testbench for cpuc_acc_alu with hand-computed expected values.
module tb_cpuc_acc_alu;
   import cpuc_package::*;

   localparam int W = DATA_WIDTH;

   logic          Clk;
   logic          RstN;
   logic [W-1:0]  const0, const1, const2, const3;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_op;
   logic [2:0]    in_src_sel;
   logic [W-1:0]  in_imm;
   logic [W-1:0]  acc_out;
   logic          out_valid;
   logic          carry_out;
   logic          zero_out;

   int n_checks;
   int n_fail;

   logic [W-1:0] ones;
   logic [W-1:0] msb;

   cpuc_acc_alu dut (
      .Clk        (Clk),
      .RstN       (RstN),
      .const0     (const0),
      .const1     (const1),
      .const2     (const2),
      .const3     (const3),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_src_sel (in_src_sel),
      .in_imm     (in_imm),
      .acc_out    (acc_out),
      .out_valid  (out_valid),
      .carry_out  (carry_out),
      .zero_out   (zero_out)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Wait for the next rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Present a command and let one edge pass.
   task automatic cmd(input logic [2:0] op, input logic [2:0] src, input logic [W-1:0] imm);
      in_valid   = 1'b1;
      in_op      = op;
      in_src_sel = src;
      in_imm     = imm;
      step();
   endtask

   task automatic idle_in();
      in_valid   = 1'b0;
      in_op      = 3'd0;
      in_src_sel = 3'd0;
      in_imm     = {W{1'b0}};
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      ones     = {W{1'b1}};
      msb      = {1'b1, {(W-1){1'b0}}};
      const0   = W'(1);
      const1   = W'(2);
      const2   = W'(3);
      const3   = W'(4);
      idle_in();
      RstN = 1'b0;

      // T1 reset values
      #2;
      check_val("t1_acc", 32'(acc_out), 32'd0);
      check_val("t1_zero", 32'(zero_out), 32'd1);
      check_val("t1_carry", 32'(carry_out), 32'd0);
      check_val("t1_ready", 32'(in_ready), 32'd1);
      check_val("t1_valid", 32'(out_valid), 32'd0);
      step();
      step();
      #2;
      RstN = 1'b1;
      step();

      // T2 LOAD const2 then ADD const3 back-to-back
      cmd(3'd1, 3'd2, {W{1'b0}});
      check_val("t2_load_acc", 32'(acc_out), 32'd3);
      check_val("t2_load_valid", 32'(out_valid), 32'd1);
      cmd(3'd2, 3'd3, {W{1'b0}});
      check_val("t2_add_acc", 32'(acc_out), 32'd7);
      check_val("t2_add_valid", 32'(out_valid), 32'd1);
      check_val("t2_add_carry", 32'(carry_out), 32'd0);
      idle_in();
      step();
      check_val("t2_valid_drop", 32'(out_valid), 32'd0);

      // T3 SUB with borrow, then SUB back to zero
      cmd(3'd1, 3'd2, {W{1'b0}});
      cmd(3'd3, 3'd3, {W{1'b0}});
      check_val("t3_sub_acc", 32'(acc_out), 32'(ones));
      check_val("t3_sub_carry", 32'(carry_out), 32'd1);
      check_val("t3_sub_zero", 32'(zero_out), 32'd0);
      cmd(3'd3, 3'd4, ones);
      check_val("t3_sub2_acc", 32'(acc_out), 32'd0);
      check_val("t3_sub2_carry", 32'(carry_out), 32'd0);
      check_val("t3_sub2_zero", 32'(zero_out), 32'd1);

      // Bitwise ops and zero operand selects
      cmd(3'd1, 3'd4, W'(8'hC5));
      cmd(3'd4, 3'd4, W'(8'h0F));
      check_val("and_acc", 32'(acc_out), 32'h05);
      cmd(3'd5, 3'd4, W'(8'h30));
      check_val("or_acc", 32'(acc_out), 32'h35);
      cmd(3'd6, 3'd4, W'(8'hFF));
      check_val("xor_acc", 32'(acc_out), 32'hCA);
      cmd(3'd2, 3'd5, ones);
      check_val("src5_zero_acc", 32'(acc_out), 32'hCA);
      check_val("src5_zero_carry", 32'(carry_out), 32'd0);
      cmd(3'd1, 3'd7, ones);
      check_val("src7_load_zero", 32'(acc_out), 32'd0);

      // T4 MUL 7*6, valid held during MUL is ignored
      cmd(3'd1, 3'd4, W'(7));
      cmd(3'd7, 3'd4, W'(6));
      check_val("t4_ready_low", 32'(in_ready), 32'd0);
      check_val("t4_no_valid", 32'(out_valid), 32'd0);
      in_op      = 3'd1;
      in_src_sel = 3'd4;
      in_imm     = W'(99);
      for (int i = 1; i < W; i++) begin
         step();
         check_val("t4_mid_ready", 32'(in_ready), 32'd0);
         check_val("t4_mid_valid", 32'(out_valid), 32'd0);
         check_val("t4_mid_acc", 32'(acc_out), 32'd7);
      end
      idle_in();
      step();
      check_val("t4_done_valid", 32'(out_valid), 32'd1);
      check_val("t4_done_acc", 32'(acc_out), 32'd42);
      check_val("t4_done_carry", 32'(carry_out), 32'd0);
      check_val("t4_done_ready", 32'(in_ready), 32'd1);
      step();
      check_val("t4_after_valid", 32'(out_valid), 32'd0);
      check_val("t4_ignored_acc", 32'(acc_out), 32'd42);

      // T5 ADD wrap, NOP keeps flags, MUL overflow
      cmd(3'd1, 3'd4, ones);
      cmd(3'd2, 3'd0, {W{1'b0}});
      check_val("t5_add_acc", 32'(acc_out), 32'd0);
      check_val("t5_add_carry", 32'(carry_out), 32'd1);
      check_val("t5_add_zero", 32'(zero_out), 32'd1);
      cmd(3'd0, 3'd4, ones);
      check_val("nop_acc", 32'(acc_out), 32'd0);
      check_val("nop_carry", 32'(carry_out), 32'd1);
      check_val("nop_valid", 32'(out_valid), 32'd1);
      cmd(3'd1, 3'd4, msb);
      cmd(3'd7, 3'd4, W'(2));
      idle_in();
      for (int i = 1; i < W; i++) begin
         step();
      end
      check_val("t5_mul_pre_valid", 32'(out_valid), 32'd0);
      step();
      check_val("t5_mul_valid", 32'(out_valid), 32'd1);
      check_val("t5_mul_acc", 32'(acc_out), 32'd0);
      check_val("t5_mul_carry", 32'(carry_out), 32'd1);

      // T6 reset mid-MUL at cnt=3
      cmd(3'd1, 3'd4, W'(9));
      cmd(3'd7, 3'd4, W'(3));
      idle_in();
      step();
      step();
      step();
      check_val("t6_busy", 32'(in_ready), 32'd0);
      RstN = 1'b0;
      #1;
      check_val("t6_rst_acc", 32'(acc_out), 32'd0);
      check_val("t6_rst_ready", 32'(in_ready), 32'd1);
      check_val("t6_rst_valid", 32'(out_valid), 32'd0);
      check_val("t6_rst_carry", 32'(carry_out), 32'd0);
      #1;
      RstN = 1'b1;
      for (int i = 0; i < W + 2; i++) begin
         step();
         check_val("t6_no_valid", 32'(out_valid), 32'd0);
      end
      cmd(3'd1, 3'd4, W'(8'h11));
      check_val("t6_load_acc", 32'(acc_out), 32'h11);
      check_val("t6_load_valid", 32'(out_valid), 32'd1);
      idle_in();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
